sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter MEM_BASE, default 1024, byte address that maps to SRAM word 0.
REQ-002 Parameter SRAM_ADDR_W, default 18, width of the SRAM halfword address bus.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  write request from the memory stage.
REQ-006 rd_en  input  1  read request from the memory stage.
REQ-007 address  input  32  byte address of the access.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load data, registered.
REQ-010 ready  output  1  high means no access is pending; the pipeline freezes on ~ready.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  SRAM_ADDR_W  SRAM halfword address.
REQ-013 SRAM_WE_N  output  1  active-low SRAM write strobe.
REQ-014 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied to 0.

Function
REQ-015 FSM states SHALL be IDLE, LO, HI, WAIT, DONE.
REQ-016 In IDLE with (rd_en|wr_en)=1, the block SHALL latch address, write_data and operation type, then go to LO on the next edge.
- Write wins if both rd_en and wr_en are high.
REQ-017 The LO to HI to WAIT to DONE to IDLE sequence SHALL advance unconditionally, one state per edge.
- WAIT length is set by REQ-033/REQ-034.
REQ-018 ready SHALL be combinational: ready = (state==DONE) | ~(rd_en|wr_en).
- ready SHALL be low in the same cycle a request first appears in IDLE.
REQ-019 Requesters SHALL hold rd_en, wr_en, address and write_data stable while ready=0.
- If a request drops mid-sequence, the FSM SHALL complete the sequence anyway.
- In that case ready SHALL be high throughout.
REQ-020 Word index SHALL be w = (latched_address - MEM_BASE) >> 2, truncated to SRAM_ADDR_W-1 bits.
- No bounds check; wrap-around by truncation.
REQ-021 SRAM_ADDR SHALL be {w,1'b0} in LO, {w,1'b1} in HI, and 0 in all other states.
REQ-022 On writes, SRAM_WE_N SHALL be 0 in LO and HI.
- SRAM_DQ SHALL drive write_data[15:0] in LO and write_data[31:16] in HI.
REQ-023 SRAM_WE_N SHALL be 1 at all other times.
- SRAM_DQ SHALL be high-Z at all other times.
REQ-024 On reads, read_data[15:0] SHALL capture SRAM_DQ at the edge leaving LO.
- read_data[31:16] SHALL capture SRAM_DQ at the edge leaving HI.
REQ-025 read_data SHALL hold its value across writes and idle periods until the next read overwrites it.
REQ-026 A new request present in DONE SHALL NOT be accepted until IDLE.
- Back-to-back accesses therefore have one extra cycle with ready=0 in IDLE.

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE, wait counter 0, read_data 0, latched registers 0.
REQ-028 During reset, SRAM_WE_N SHALL be 1, SRAM_DQ high-Z and SRAM_ADDR 0.
REQ-029 During reset, ready SHALL follow REQ-018 with state=IDLE.
REQ-030 Reset asserted mid-write SHALL deassert SRAM_WE_N immediately, without waiting for a clock.
REQ-031 After reset release, a pending request SHALL restart from IDLE.

Configuration
REQ-032 Macro SRAM_EXTRA_WAIT_EN SHALL set the WAIT length.
REQ-033 When SRAM_EXTRA_WAIT_EN is undefined, WAIT SHALL last 1 cycle.
- ready is then low for 4 cycles per access, measured from request appearance in IDLE.
REQ-034 When SRAM_EXTRA_WAIT_EN is defined, WAIT SHALL last 3 cycles using a 2-bit counter.
- ready is then low for 6 cycles per access.

Verification
REQ-035 Write 0xDEADBEEF to address 1024 -> SRAM_ADDR=0 with DQ=0xBEEF, then SRAM_ADDR=1 with DQ=0xDEAD, WE_N=0 in both; ready low 4 cycles (6 with macro).
REQ-036 Read address 1032 with SRAM model holding 0x5678 at SRAM_ADDR 4 and 0x1234 at SRAM_ADDR 5 -> read_data=0x12345678 at DONE; ready rises in DONE.
REQ-037 rd_en=wr_en=1, address 1028, write_data 0xA5A5_0F0F -> write performed at SRAM_ADDR 2 and 3; read_data unchanged.
REQ-038 Assert rst during HI of a write -> WE_N=1 and DQ=Z immediately, state IDLE, read_data=0; request re-run completes normally.
REQ-039 Two back-to-back reads at 1024 and 1028 -> second access starts in the IDLE following DONE; read_data updates to each word in turn.
REQ-040 Address 1024+4*2^17 -> wraps to SRAM_ADDR 0 and 1.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller
//   Bridges a 32-bit memory-stage load/store port onto a 16-bit asynchronous
//   SRAM. Each access is split into two halfword phases (LO then HI),
//   followed by a settle period (WAIT) and a completion cycle (DONE).
//
//   Build option:
//     SRAM_EXTRA_WAIT_EN  when defined, WAIT lasts 3 cycles (2-bit counter);
//                         otherwise WAIT lasts 1 cycle.
//
//   Parameters:
//     MEM_BASE     byte address that maps to SRAM word 0
//     SRAM_ADDR_W  width of the SRAM halfword address bus
//
//   Ports:
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     wr_en, rd_en    store / load request (write wins if both are high)
//     address         byte address of the access
//     write_data      store data
//     read_data       load data, registered, held until the next read
//     ready           high when no access is pending (pipeline freezes on ~ready)
//     SRAM_DQ         bidirectional SRAM data bus
//     SRAM_ADDR       SRAM halfword address
//     SRAM_WE_N       active-low write strobe
//     SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  tied low
//     state_dbg       current FSM state (IDLE=0, LO=1, HI=2, WAIT=3, DONE=4)
//
//   Handshake: a request is the level (rd_en|wr_en). While ready is low the
//   requester holds rd_en, wr_en, address and write_data stable. ready rises
//   in DONE; the edge leaving DONE is the edge on which the requester
//   advances. A request still present in DONE is only taken in the following
//   IDLE cycle, so back-to-back accesses see one extra ready-low IDLE cycle.
module sram_controller #(
    parameter int MEM_BASE    = 1024,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        is_write_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;

`ifdef SRAM_EXTRA_WAIT_EN
    logic [1:0]  wait_cnt;
`endif

    // Word index of the incoming request and of the latched request.
    // Out-of-range addresses simply wrap by truncation.
    logic [SRAM_ADDR_W-2:0] w_in;
    logic [SRAM_ADDR_W-2:0] w_q;
    assign w_in = (SRAM_ADDR_W-1)'((address - 32'(MEM_BASE)) >> 2);
    assign w_q  = (SRAM_ADDR_W-1)'((addr_q  - 32'(MEM_BASE)) >> 2);

    assign ready     = (state == DONE) | ~(rd_en | wr_en);
    assign state_dbg = state;

    // Only drive the bus while the write strobe is active; both come from
    // registers cleared by the asynchronous reset, so reset releases the
    // bus and the strobe without waiting for a clock.
    assign SRAM_DQ = dq_oe_q ? dq_out_q : 16'hzzzz;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // SRAM_ADDR / SRAM_WE_N / bus drive are registered: they are loaded on
    // the edge entering a state with the values that state requires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            read_data  <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
`ifdef SRAM_EXTRA_WAIT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en | wr_en) begin
                        addr_q     <= address;
                        wdata_q    <= write_data;
                        is_write_q <= wr_en;
                        state      <= LO;
                        SRAM_ADDR  <= {w_in, 1'b0};
                        SRAM_WE_N  <= ~wr_en;
                        dq_oe_q    <= wr_en;
                        dq_out_q   <= write_data[15:0];
                    end
                end
                LO: begin
                    state     <= HI;
                    SRAM_ADDR <= {w_q, 1'b1};
                    dq_out_q  <= wdata_q[31:16];
                    if (!is_write_q) read_data[15:0] <= SRAM_DQ;
                end
                HI: begin
                    state     <= WAIT;
                    SRAM_ADDR <= '0;
                    SRAM_WE_N <= 1'b1;
                    dq_oe_q   <= 1'b0;
                    if (!is_write_q) read_data[31:16] <= SRAM_DQ;
`ifdef SRAM_EXTRA_WAIT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT: begin
`ifdef SRAM_EXTRA_WAIT_EN
                    if (wait_cnt == 2'd2) begin
                        wait_cnt <= '0;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
`else
                    state <= DONE;
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Directed bench for sram_controller. A small SRAM model answers reads
//   combinationally from a preset array while model_en is set, so the
//   controller's own high-Z can be observed when it is cleared.
module tb_sram_controller;

    localparam int AW = 18;
`ifdef SRAM_EXTRA_WAIT_EN
    localparam int EXP_LOW = 6;
`else
    localparam int EXP_LOW = 4;
`endif
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [31:0]   address, write_data, read_data;
    logic          ready;
    wire  [15:0]   sram_dq;
    logic [AW-1:0] sram_addr;
    logic          sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;
    logic [2:0]    state_dbg;

    logic          model_en;
    logic [15:0]   mem [0:15];

    sram_controller #(.MEM_BASE(1024), .SRAM_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n),
        .state_dbg  (state_dbg)
    );

    assign sram_dq = (model_en && sram_we_n) ? mem[sram_addr[3:0]] : 16'hzzzz;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-cycle observations of one access, index 0 = the IDLE cycle.
    logic [AW-1:0] obs_addr  [0:15];
    logic          obs_we    [0:15];
    logic [15:0]   obs_dq    [0:15];
    logic [2:0]    obs_state [0:15];

    // ---------------- driver tasks ----------------
    // Called just after a negedge. Applies a request and samples once per
    // cycle until ready rises; returns with the DUT in DONE.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, output int low);
        wr_en = wr; rd_en = rd; address = addr; write_data = wd;
        low = 0;
        #1;
        while (!ready && low < 16) begin
            obs_addr[low]  = sram_addr;
            obs_we[low]    = sram_we_n;
            obs_dq[low]    = sram_dq;
            obs_state[low] = state_dbg;
            low++;
            @(negedge clk); #1;
        end
    endtask

    // Lets the DUT leave DONE, then withdraws the request.
    task automatic release_req();
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_write_phases(input string tag, input logic [AW-1:0] w2,
                                      input logic [31:0] wd);
        check({tag, "_idle_state"}, 32'(obs_state[0]), 32'(S_IDLE));
        check({tag, "_lo_addr"},    32'(obs_addr[1]),  32'(w2));
        check({tag, "_lo_we"},      32'(obs_we[1]),    32'(1'b0));
        check({tag, "_lo_dq"},      32'(obs_dq[1]),    32'(wd[15:0]));
        check({tag, "_hi_addr"},    32'(obs_addr[2]),  32'(w2 + 1'b1));
        check({tag, "_hi_we"},      32'(obs_we[2]),    32'(1'b0));
        check({tag, "_hi_dq"},      32'(obs_dq[2]),    32'(wd[31:16]));
        check({tag, "_wait_we"},    32'(obs_we[3]),    32'(1'b1));
        check({tag, "_wait_addr"},  32'(obs_addr[3]),  32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int low;
        int cyc;
        logic [15:0] zz;
        zz = 16'hzzzz;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        mem[0] = 16'hAAAA; mem[1] = 16'h5555;
        mem[2] = 16'hC3C3; mem[3] = 16'h3C3C;
        mem[4] = 16'h5678; mem[5] = 16'h1234;
        model_en = 1'b0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready",     32'(ready),     32'(1));
        check("rst_we_n",      32'(sram_we_n), 32'(1));
        check("rst_dq_z",      32'(sram_dq),   32'(zz));
        check("rst_addr",      32'(sram_addr), 32'(0));
        check("rst_read_data", read_data,      32'h0);
        check("rst_state",     32'(state_dbg), 32'(S_IDLE));
        check("rst_tie_lo",    32'({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}), 32'(0));
        rd_en = 1'b1; #1;
        check("rst_ready_req", 32'(ready),     32'(0));
        rd_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Write 0xDEADBEEF to 1024
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, low);
        check("wr_low_cycles", 32'(low), 32'(EXP_LOW));
        check_write_phases("wr", 18'd0, 32'hDEADBEEF);
        check("wr_wait_dq_z", 32'(obs_dq[3]), 32'(zz));
        check("wr_done_state", 32'(state_dbg), 32'(S_DONE));
        check("wr_read_data_hold", read_data, 32'h0);
        release_req();

        // Read 1032 -> halfwords 4 and 5
        model_en = 1'b1;
        access(1'b0, 1'b1, 32'd1032, 32'h0, low);
        check("rd_low_cycles", 32'(low), 32'(EXP_LOW));
        check("rd_lo_addr",    32'(obs_addr[1]), 32'(4));
        check("rd_hi_addr",    32'(obs_addr[2]), 32'(5));
        check("rd_we_n",       32'(obs_we[1] & obs_we[2]), 32'(1));
        check("rd_done_state", 32'(state_dbg), 32'(S_DONE));
        check("rd_data",       read_data, 32'h12345678);
        release_req();

        // Both enables: write wins
        model_en = 1'b0;
        access(1'b1, 1'b1, 32'd1028, 32'hA5A50F0F, low);
        check("rw_low_cycles", 32'(low), 32'(EXP_LOW));
        check_write_phases("rw", 18'd2, 32'hA5A50F0F);
        check("rw_read_data_hold", read_data, 32'h12345678);
        release_req();

        // Back-to-back reads at 1024 and 1028
        model_en = 1'b1;
        access(1'b0, 1'b1, 32'd1024, 32'h0, low);
        check("b2b1_low_cycles", 32'(low), 32'(EXP_LOW));
        check("b2b1_data", read_data, 32'h5555AAAA);
        @(posedge clk); #1;
        @(negedge clk);
        access(1'b0, 1'b1, 32'd1028, 32'h0, low);
        check("b2b2_low_cycles", 32'(low), 32'(EXP_LOW));
        check("b2b2_idle_state", 32'(obs_state[0]), 32'(S_IDLE));
        check("b2b2_lo_addr",    32'(obs_addr[1]), 32'(2));
        check("b2b2_data", read_data, 32'h3C3CC3C3);
        release_req();

        // Request dropped in LO: sequence completes, ready stays high
        rd_en = 1'b1; address = 32'd1024;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk); #1;
        check("drop_lo_ready", 32'(ready), 32'(1));
        check("drop_lo_state", 32'(state_dbg), 32'(S_LO));
        @(negedge clk); #1;
        check("drop_hi_ready", 32'(ready), 32'(1));
        check("drop_hi_state", 32'(state_dbg), 32'(S_HI));
        cyc = 0;
        while (state_dbg != S_IDLE && cyc < 16) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("drop_back_idle", 32'(state_dbg), 32'(S_IDLE));
        check("drop_data", read_data, 32'h5555AAAA);
        @(negedge clk);

        // Reset asserted during HI of a write
        model_en = 1'b0;
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h0BADCAFE;
        @(negedge clk); @(negedge clk); #1;
        check("mid_hi_we", 32'(sram_we_n), 32'(0));
        check("mid_hi_dq", 32'(sram_dq), 32'h0000_0BAD);
        rst = 1'b1; #1;
        check("mid_rst_we_n",  32'(sram_we_n), 32'(1));
        check("mid_rst_dq_z",  32'(sram_dq), 32'(zz));
        check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("mid_rst_addr",  32'(sram_addr), 32'(0));
        check("mid_rst_data",  read_data, 32'h0);
        @(negedge clk); rst = 1'b0;
        access(1'b1, 1'b0, 32'd1024, 32'h0BADCAFE, low);
        check("rerun_low_cycles", 32'(low), 32'(EXP_LOW));
        check_write_phases("rerun", 18'd0, 32'h0BADCAFE);
        release_req();

        // Address wraps by truncation
        access(1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd131072, 32'hF00D1234, low);
        check("wrap_low_cycles", 32'(low), 32'(EXP_LOW));
        check_write_phases("wrap", 18'd0, 32'hF00D1234);
        check("wrap_read_data_hold", read_data, 32'h0);
        release_req();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
